max7219_scan_ctrl: RTL
======================

// Module: max7219_scan_ctrl
// PURPOSE
//  Sequencer for a MAX7219 8-digit display. Runs power-up delay, register init, then periodic/on-demand digit refresh.
//  Emits 16-bit {addr,data} words over a valid/ready handshake to the downstream word serializer (max7219_word_tx).
//  Sits between user logic (digit values, brightness) and the serializer that drives seg_clk/seg_cs/seg_din.
// PARAMETERS
//  CLK_FRE      50_000_000  clk frequency, Hz
//  POWERUP_US   1000        delay after reset before the first word, us
//  REFRESH_HZ   50          periodic full-frame rewrite rate
//  DECODE_MODE  8'hFF       value written to reg 0x09 (Code-B on all digits)
//  SCAN_LIMIT   3'd7        value written to reg 0x0B (digits 0..7 scanned)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  digits_in    in   32  8 BCD nibbles; digit1=[3:0] .. digit8=[31:28]
//  digits_load  in   1   1-cycle strobe: capture digits_in into shadow buffer
//  intensity    in   4   brightness, level-sampled
//  blank        in   1   level: send 0x0F (Code-B blank) for every digit
//  word_data    out  16  {addr[15:8], data[7:0]} to serializer
//  word_valid   out  1   word_data valid
//  word_ready   in   1   serializer accepts word when word_valid&&word_ready
//  busy         out  1   high unless in S_IDLE
//  frame_done   out  1   1-cycle pulse after last digit word accepted
// BEHAVIOUR
//  - Clock is clk; reset is rst_n, asynchronous and active-low. Reset mid-operation aborts any word.
//  - Reset values: word_valid=0, word_data=16'h0000, busy=1, frame_done=0, shadow=0, dirty=0, state=S_PWRUP.
//  - Handshake: word_data stable while word_valid=1 and !word_ready. On accept, next word is registered same edge.
//    word_valid stays 1 (back-to-back, zero bubble). Accept of the final word of a sequence drops word_valid.
//  - S_PWRUP: count CLK_FRE/1_000_000*POWERUP_US cycles, then S_INIT.
//  - S_INIT: 6 words in order: 0F00 (test off), 0C00 (shutdown), 09<DECODE_MODE>, 0B<{5'd0,SCAN_LIMIT}>,
//    0A<{4'h0,intensity}>, 0C01 (normal). intensity is sampled at load of the 0A word into int_last. Then S_FRAME.
//  - S_FRAME entry: snapshot shadow into frame buffer, clear dirty/pending. If intensity!=int_last, first word is 0A0<intensity>.
//    Then words 01..08 with data {4'h0,nibble}, or 8'h0F when blank (blank sampled per word).
//  - After word 08 accepted: frame_done=1 for 1 cycle; go to S_IDLE; busy=0 from next cycle.
//  - Refresh timer: period CLK_FRE/REFRESH_HZ, free-running from exit of S_INIT, wraps to 0. Expiry sets pending.
//  - S_IDLE -> S_FRAME when dirty||pending. Frame start is the cycle after the condition is seen.
//  - digits_load: captures to shadow and sets dirty in any state. During a frame, the frame buffer is untouched (no tearing).
//    dirty triggers the next frame. Load on the snapshot cycle: new value goes into the frame and dirty ends clear.
//  - Timer expiry and load in the same cycle, or repeated expiries: a single pending frame, never queued twice.
//  - Counters: power-up and refresh counters are 32-bit. Word index is 4-bit, 0..8. No arithmetic overflow paths.
// STRUCTURE
//  - max7219_pkg: register address localparams (NOOP..TEST 0x00..0x0F), state enum {S_PWRUP,S_INIT,S_FRAME,S_IDLE},
//    init word table constant.
//  - Single module. The serializer (max7219_word_tx) is a separate block, not instantiated here. No sub-module required.
// TESTING (CLK_FRE=1_000_000, POWERUP_US=10, REFRESH_HZ=1000; word_ready tied 1 unless stated)
//  1 Reset release -> first word_valid exactly 10 cycles later. Words 0F00,0C00,09FF,0B07,0A0<int>,0C01 on consecutive cycles.
//  2 digits_load with 32'h8765_4321 -> words 0101,0202..0808, then frame_done pulse, then busy=0.
//  3 word_ready stalls random 0-5 cycles -> word_data held stable. Sequence unchanged. No word dropped or duplicated.
//  4 Load 32'h1111_1111 mid-frame of 32'h2222_2222 -> current frame all 02, next frame all 01.
//  5 intensity 3->9 in S_IDLE, then timer expiry -> frame begins 0A09, then 01..08. Next frame has no 0A word.
//  6 blank=1 -> data 0F on all 8 digits. rst_n low mid-word -> word_valid=0 immediately, init sequence restarts.

Source files
------------

// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 scan controller: register map,
// sequencer state encodings and the power-up register table.
package max7219_pkg;

  localparam logic [7:0] REG_NOOP       = 8'h00;
  localparam logic [7:0] REG_DIGIT0     = 8'h01;
  localparam logic [7:0] REG_DIGIT1     = 8'h02;
  localparam logic [7:0] REG_DIGIT2     = 8'h03;
  localparam logic [7:0] REG_DIGIT3     = 8'h04;
  localparam logic [7:0] REG_DIGIT4     = 8'h05;
  localparam logic [7:0] REG_DIGIT5     = 8'h06;
  localparam logic [7:0] REG_DIGIT6     = 8'h07;
  localparam logic [7:0] REG_DIGIT7     = 8'h08;
  localparam logic [7:0] REG_DECODE     = 8'h09;
  localparam logic [7:0] REG_INTENSITY  = 8'h0A;
  localparam logic [7:0] REG_SCAN_LIMIT = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN   = 8'h0C;
  localparam logic [7:0] REG_TEST       = 8'h0F;

  localparam logic [1:0] S_PWRUP = 2'd0;
  localparam logic [1:0] S_INIT  = 2'd1;
  localparam logic [1:0] S_FRAME = 2'd2;
  localparam logic [1:0] S_IDLE  = 2'd3;

  localparam logic [3:0] INIT_LAST     = 4'd5;
  localparam logic [3:0] INIT_INT_IDX  = 4'd4;
  localparam logic [3:0] DIGIT_LAST    = 4'd8;
  localparam logic [7:0] CODE_B_BLANK  = 8'h0F;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } word_t;

  // Power-up register table; shutdown is released only after every
  // other register holds a sane value so no garbage is ever displayed.
  function automatic word_t init_word(input logic [3:0] idx,
                                      input logic [7:0] decode,
                                      input logic [2:0] scan,
                                      input logic [3:0] inten);
    word_t w;
    case (idx)
      4'd0:    w = '{addr: REG_TEST,       data: 8'h00};
      4'd1:    w = '{addr: REG_SHUTDOWN,   data: 8'h00};
      4'd2:    w = '{addr: REG_DECODE,     data: decode};
      4'd3:    w = '{addr: REG_SCAN_LIMIT, data: {5'd0, scan}};
      4'd4:    w = '{addr: REG_INTENSITY,  data: {4'h0, inten}};
      default: w = '{addr: REG_SHUTDOWN,   data: 8'h01};
    endcase
    return w;
  endfunction

  // Digit n (1..8) lives in nibble n-1 of the frame; blank forces Code-B blank.
  function automatic word_t digit_word(input logic [3:0] n,
                                       input logic [31:0] frame,
                                       input logic blank);
    word_t w;
    logic [4:0] sh;
    logic [31:0] shifted;
    sh      = {n[2:0] - 3'd1, 2'b00};
    shifted = frame >> sh;
    w.addr  = {4'h0, n};
    w.data  = blank ? CODE_B_BLANK : {4'h0, shifted[3:0]};
    return w;
  endfunction

endpackage

// File: rtl/max7219_scan_ctrl.sv
// MAX7219 sequencer: power-up wait, register init, then tear-free digit
// refresh on digit load or refresh-timer expiry, as {addr,data} words.
module max7219_scan_ctrl
  import max7219_pkg::*;
#(
  parameter int unsigned CLK_FRE     = 50_000_000,
  parameter int unsigned POWERUP_US  = 1000,
  parameter int unsigned REFRESH_HZ  = 50,
  parameter logic [7:0]  DECODE_MODE = 8'hFF,
  parameter logic [2:0]  SCAN_LIMIT  = 3'd7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digits_in,
  input  logic        digits_load,
  input  logic [3:0]  intensity,
  input  logic        blank,
  output logic [15:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [31:0] PWRUP_CYCLES   = CLK_FRE / 32'd1_000_000 * POWERUP_US;
  localparam logic [31:0] REFRESH_CYCLES = CLK_FRE / REFRESH_HZ;
  localparam logic [31:0] PWRUP_LAST     = (PWRUP_CYCLES == 32'd0) ? 32'd0 : PWRUP_CYCLES - 32'd1;
  localparam logic [31:0] REFRESH_LAST   = (REFRESH_CYCLES == 32'd0) ? 32'd0 : REFRESH_CYCLES - 32'd1;

  logic [1:0]  state;
  logic [31:0] pwr_cnt;
  logic [31:0] ref_cnt;
  logic        timer_on;
  logic [3:0]  idx;
  logic [31:0] shadow;
  logic [31:0] fbuf;
  logic        dirty;
  logic        pending;
  logic [3:0]  int_last;

  logic        accept;
  logic        expire;
  logic        frame_entry;
  logic        init_exit;
  logic [31:0] snap;
  logic [3:0]  idx_next;

  // A frame is entering when we sit in S_FRAME without a word in flight:
  // word_valid only drops inside a frame on its final accept, which also leaves S_FRAME.
  assign accept      = word_valid && word_ready;
  assign expire      = timer_on && (ref_cnt == REFRESH_LAST);
  assign frame_entry = (state == S_FRAME) && !word_valid;
  assign init_exit   = (state == S_INIT) && accept && (idx == INIT_LAST);
  assign snap        = digits_load ? digits_in : shadow;
  assign idx_next    = idx + 4'd1;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_on <= 1'b0;
      ref_cnt  <= 32'd0;
    end else begin
      if (init_exit) begin
        timer_on <= 1'b1;
      end
      if (timer_on) begin
        ref_cnt <= expire ? 32'd0 : ref_cnt + 32'd1;
      end
    end
  end

  // The snapshot clears both triggers; a load or expiry on that same cycle
  // is already covered by the frame being started.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= 32'd0;
      dirty   <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (digits_load) begin
        shadow <= digits_in;
      end
      if (frame_entry) begin
        dirty   <= 1'b0;
        pending <= 1'b0;
      end else begin
        if (digits_load) begin
          dirty <= 1'b1;
        end
        if (expire) begin
          pending <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_PWRUP;
      pwr_cnt    <= 32'd0;
      idx        <= 4'd0;
      word_valid <= 1'b0;
      word_data  <= 16'h0000;
      frame_done <= 1'b0;
      fbuf       <= 32'd0;
      int_last   <= 4'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_PWRUP: begin
          if (pwr_cnt == PWRUP_LAST) begin
            state      <= S_INIT;
            idx        <= 4'd0;
            word_valid <= 1'b1;
            word_data  <= init_word(4'd0, DECODE_MODE, SCAN_LIMIT, intensity);
          end else begin
            pwr_cnt <= pwr_cnt + 32'd1;
          end
        end
        S_INIT: begin
          if (accept) begin
            if (idx == INIT_LAST) begin
              word_valid <= 1'b0;
              state      <= S_FRAME;
            end else begin
              idx       <= idx_next;
              word_data <= init_word(idx_next, DECODE_MODE, SCAN_LIMIT, intensity);
              if (idx_next == INIT_INT_IDX) begin
                int_last <= intensity;
              end
            end
          end
        end
        S_FRAME: begin
          if (!word_valid) begin
            fbuf       <= snap;
            word_valid <= 1'b1;
            if (intensity != int_last) begin
              word_data <= {REG_INTENSITY, 4'h0, intensity};
              int_last  <= intensity;
              idx       <= 4'd0;
            end else begin
              word_data <= digit_word(4'd1, snap, blank);
              idx       <= 4'd1;
            end
          end else if (accept) begin
            if (idx == DIGIT_LAST) begin
              word_valid <= 1'b0;
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              idx       <= idx_next;
              word_data <= digit_word(idx_next, fbuf, blank);
            end
          end
        end
        S_IDLE: begin
          if (dirty || pending) begin
            state <= S_FRAME;
          end
        end
        default: begin
          state <= S_PWRUP;
        end
      endcase
    end
  end

endmodule
